// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Brief    : N-read / 1-write integer register file with a busy scoreboard
//            and a hardware clear sequencer. Build option RF_BYPASS_EN adds
//            a same-cycle write-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  rsv_en,
  input  logic [AW-1:0]         rsv_addr,
  input  logic                  clr_req,
  output logic                  ready
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   mem_q [NREGS];

  logic              w_ready;
  logic              w_accept;
  logic              w_wr_ok;
  logic              w_rsv_ok;
  logic              w_mem_we;
  logic [AW-1:0]     w_mem_addr;
  logic [XLEN-1:0]   w_mem_wdata;

  assign w_ready  = (state_q == ST_READY);
  assign ready    = w_ready;
  // A clear request pre-empts any write or reservation in the same cycle.
  assign w_accept = w_ready && !clr_req;
  assign w_wr_ok  = w_accept && wr_en  && (wr_addr  != '0);
  assign w_rsv_ok = w_accept && rsv_en && (rsv_addr != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    w_mem_we    = 1'b0;
    w_mem_addr  = cnt_q;
    w_mem_wdata = '0;
    case (state_q)
      ST_CLEAR: begin
        w_mem_we = 1'b1;
        cnt_d    = cnt_q + AW'(1);
        if (cnt_q == AW'(NREGS - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = '0;
        end else begin
          if (w_wr_ok) begin
            w_mem_we          = 1'b1;
            w_mem_addr        = wr_addr;
            w_mem_wdata       = wr_data;
            busy_d[wr_addr]   = 1'b0;
          end
          // Applied after the release so a same-address reservation wins.
          if (w_rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage has no reset; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_addr] <= w_mem_wdata;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic            w_busy;
    logic            w_byp;

    assign w_addr = rd_addr[i*AW +: AW];
`ifdef RF_BYPASS_EN
    assign w_byp = wr_en && w_ready && (wr_addr != '0) && (w_addr == wr_addr);
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_ready && (w_addr != '0)) begin
        if (w_byp) begin
          w_data = wr_data;
          w_busy = rsv_en && (rsv_addr == wr_addr);
        end else begin
          w_data = mem_q[w_addr];
          w_busy = busy_q[w_addr];
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = w_data;
    assign rd_busy[i]              = w_busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Directed self-checking bench for regfile_sb with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 2;
  localparam int AW    = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  rsv_en;
  logic [AW-1:0]         rsv_addr;
  logic                  clr_req;
  logic                  ready;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: clear_left counts clear cycles still owed before use.
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_busy = '0;
  int               clear_left = NREGS;
  logic             m_ready;
  assign m_ready = (clear_left == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_left <= NREGS;
      m_busy     <= '0;
    end else if (clear_left > 0) begin
      m_regs[NREGS - clear_left] <= '0;
      clear_left <= clear_left - 1;
    end else if (clr_req) begin
      clear_left <= NREGS;
      m_busy     <= '0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] <= wr_data;
        m_busy[wr_addr] <= 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] <= 1'b1;
    end
  end

  logic [AW-1:0]   c_a;
  logic [XLEN-1:0] c_ed;
  logic            c_eb;
  logic            c_byp;

  always @(negedge clk) begin
    chk("ready", {31'b0, ready}, {31'b0, m_ready});
    for (int i = 0; i < NREAD; i++) begin
      c_a = rd_addr[i*AW +: AW];
`ifdef RF_BYPASS_EN
      c_byp = wr_en && (wr_addr != 0) && (c_a == wr_addr);
`else
      c_byp = 1'b0;
`endif
      if (!m_ready || c_a == 0) begin
        c_ed = '0;
        c_eb = 1'b0;
      end else if (c_byp) begin
        c_ed = wr_data;
        c_eb = rsv_en && (rsv_addr == wr_addr);
      end else begin
        c_ed = m_regs[c_a];
        c_eb = m_busy[c_a];
      end
      chk("model_rd_data", rd_data[i*XLEN +: XLEN], c_ed);
      chk("model_rd_busy", {31'b0, rd_busy[i]}, {31'b0, c_eb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    clr_req  = 1'b0;
  endtask

  task automatic wait_clear(input string name);
    for (int k = 0; k <= NREGS; k++) begin
      @(negedge clk);
      chk(name, {31'b0, ready}, (k == NREGS) ? 32'd1 : 32'd0);
    end
    tick();
  endtask

  task automatic sweep_zero(input string name);
    for (int k = 0; k < NREGS / 2; k++) begin
      rd_addr = {AW'(2 * k + 1), AW'(2 * k)};
      @(negedge clk);
      chk(name, rd_data[XLEN-1:0], 32'h0);
      chk(name, rd_data[2*XLEN-1:XLEN], 32'h0);
      chk(name, {30'b0, rd_busy}, 32'h0);
      tick();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    wait_clear("rst_release_ready");
    sweep_zero("after_reset_zero");

    // Write x5, read on both ports next cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
    tick();
    idle_inputs();
    @(negedge clk);
    chk("x5_port0", rd_data[XLEN-1:0], 32'hDEADBEEF);
    chk("x5_port1", rd_data[2*XLEN-1:XLEN], 32'hDEADBEEF);
    tick();

    // Write to x0 is dropped.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
    tick();
    idle_inputs();
    rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("x0_zero", rd_data[XLEN-1:0], 32'h0);
    tick();

    // Scoreboard: reserve, release, simultaneous reserve+write.
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    idle_inputs();
    rd_addr = {5'd7, 5'd7};
    @(negedge clk);
    chk("x7_busy", {31'b0, rd_busy[0]}, 32'd1);
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("x7_released", {31'b0, rd_busy[1]}, 32'd0);
    chk("x7_data", rd_data[XLEN-1:0], 32'h55);
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    idle_inputs();
    rd_addr = {5'd9, 5'd9};
    @(negedge clk);
    chk("x9_data", rd_data[2*XLEN-1:XLEN], 32'h99);
    chk("x9_busy", {31'b0, rd_busy[1]}, 32'd1);
    tick();

    // Same-cycle read and write of x3.
    rd_addr = {5'd3, 5'd3};
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    chk("x3_same_cycle", rd_data[XLEN-1:0], 32'hA5A5A5A5);
`else
    chk("x3_same_cycle", rd_data[XLEN-1:0], 32'h0);
`endif
    chk("x3_same_busy", {31'b0, rd_busy[0]}, 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("x3_next_cycle", rd_data[XLEN-1:0], 32'hA5A5A5A5);
    tick();

    // Clear request with a pending write and reservation.
    clr_req = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    tick();
    idle_inputs();
    wait_clear("clr_ready");
    sweep_zero("after_clr_zero");

    // Reset asserted part-way through a clear sequence.
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h2020;
    tick();
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_ready", {31'b0, ready}, 32'd0);
      tick();
    end
    rst_n = 1'b1;
    wait_clear("rst_mid_clear_ready");
    rd_addr = {5'd20, 5'd20};
    @(negedge clk);
    chk("x20_cleared", rd_data[XLEN-1:0], 32'h0);
    tick();

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
